// File: rtl/viterbi_ctrl_pkg.sv
// =============================================================================
// viterbi_ctrl_pkg : shared types and constants for the Viterbi frame controller
// Revision: 1.0
// =============================================================================
`default_nettype none

package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } vctrl_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, left shift: feedback from bits 15,13,12,10
    localparam logic [15:0] c_lfsr_taps    = 16'hB400;
    localparam logic [15:0] c_pay_seed_sub = 16'hACE1;
    localparam logic [15:0] c_err_seed_sub = 16'h1D0F;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & c_lfsr_taps)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/viterbi_frame_ctrl_if.sv
// =============================================================================
// viterbi_frame_ctrl_if : control, encoder/decoder and result signals of the
// frame controller. Revision: 1.0
// =============================================================================
`default_nettype none

interface viterbi_frame_ctrl_if #(
    parameter int ERR_W = 5
) ();
    logic             start;
    logic             abort;
    logic [15:0]      seed;
    logic [ERR_W:0]   err_thresh;
    logic             encoder_i;
    logic             enable_encoder_i;
    logic [1:0]       err_inj;
    logic             decoder_o;
    logic             busy;
    logic             done;
    logic [15:0]      bit_err_ct;
    logic [15:0]      inj_ct;

    modport master (
        output start, abort, seed, err_thresh, decoder_o,
        input  encoder_i, enable_encoder_i, err_inj, busy, done, bit_err_ct, inj_ct
    );

    modport slave (
        input  start, abort, seed, err_thresh, decoder_o,
        output encoder_i, enable_encoder_i, err_inj, busy, done, bit_err_ct, inj_ct
    );
endinterface

`default_nettype wire

// File: rtl/viterbi_frame_ctrl_lfsr16.sv
// =============================================================================
// lfsr16 : 16-bit Fibonacci LFSR with load, advance and zero-seed substitution.
// Revision: 1.0
// =============================================================================
`default_nettype none

module lfsr16
    import viterbi_ctrl_pkg::*;
#(
    parameter logic [15:0] ZERO_SUB = 16'hACE1,
    parameter int          OUT_W    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [15:0]      seed_i,
    input  logic             advance_i,
    output logic [OUT_W-1:0] next_o
);
    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 16'h0000) ? ZERO_SUB : seed_i;
        end else if (advance_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 16'h0000;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state view lets the owner register outputs in the same edge as a load
    assign next_o = state_d[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/viterbi_frame_ctrl.sv
// =============================================================================
// viterbi_frame_ctrl : drives one payload frame + zero tail into the encoder,
// injects channel errors and scores decoder output. Revision: 1.0
// =============================================================================
`default_nettype none

module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int TAIL_LEN  = 8,
    parameter int DEC_LAT   = 40,
    parameter int ERR_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    viterbi_frame_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_LEN + DEC_LAT + 1);
    localparam logic [CNT_W-1:0] c_run_last   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(FRAME_LEN + TAIL_LEN - 1);
    localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(FRAME_LEN + DEC_LAT - 1);

    vctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W:0]     thresh_q, thresh_d;
    logic               accept, aborting;
    logic               pay_bit_d;
    logic [ERR_W-1:0]   err_bits_d;
    logic               enc_q, enc_d, en_q, en_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]         inj_q, inj_d;
    logic [15:0]        bit_err_q, inj_ct_q;
    logic [DEC_LAT-1:0] ref_vld_q, ref_bit_q;
    logic               miscompare;

    assign accept   = (state_q == ST_IDLE) && bus.start;
    assign aborting = (state_q != ST_IDLE) && bus.abort;

    lfsr16 #(.ZERO_SUB(c_pay_seed_sub), .OUT_W(1)) u_pay_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .seed_i    (bus.seed),
        .advance_i (state_q == ST_RUN),
        .next_o    (pay_bit_d)
    );

    lfsr16 #(.ZERO_SUB(c_err_seed_sub), .OUT_W(ERR_W)) u_err_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .seed_i    ({bus.seed[7:0], bus.seed[15:8]}),
        .advance_i (en_q),
        .next_o    (err_bits_d)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        thresh_d = thresh_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = cnt_q;
                if (bus.start) begin
                    state_d  = ST_RUN;
                    cnt_d    = '0;
                    thresh_d = bus.err_thresh;
                end
            end
            ST_RUN:   if (cnt_q == c_run_last)   state_d = ST_FLUSH;
            ST_FLUSH: if (cnt_q == c_flush_last) state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == c_drain_last) state_d = ST_DONE;
            ST_DONE: begin
                cnt_d   = cnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (aborting) begin
            state_d = ST_IDLE;
        end

        // Outputs are registered from the next state so they line up with it
        en_d   = (state_d == ST_RUN) || (state_d == ST_FLUSH);
        enc_d  = (state_d == ST_RUN) && pay_bit_d;
        inj_d  = (en_d && ({1'b0, err_bits_d} < thresh_d)) ? 2'b01 : 2'b00;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            thresh_q <= '0;
            enc_q    <= 1'b0;
            en_q     <= 1'b0;
            inj_q    <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            thresh_q <= thresh_d;
            enc_q    <= enc_d;
            en_q     <= en_d;
            inj_q    <= inj_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Only payload bits carry a valid tag, so tail bits fall out unscored
    always_ff @(posedge clk) begin
        if (rst || aborting) begin
            ref_vld_q <= '0;
            ref_bit_q <= '0;
        end else begin
            ref_vld_q <= DEC_LAT'({ref_vld_q, state_q == ST_RUN});
            ref_bit_q <= DEC_LAT'({ref_bit_q, enc_q});
        end
    end

    assign miscompare = ref_vld_q[DEC_LAT-1] & (ref_bit_q[DEC_LAT-1] ^ bus.decoder_o);

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            bit_err_q <= 16'h0000;
            inj_ct_q  <= 16'h0000;
        end else if (!aborting) begin
            if (miscompare && (bit_err_q != 16'hFFFF)) begin
                bit_err_q <= bit_err_q + 16'd1;
            end
            if ((inj_q != 2'b00) && (inj_ct_q != 16'hFFFF)) begin
                inj_ct_q <= inj_ct_q + 16'd1;
            end
        end
    end

    assign bus.encoder_i        = enc_q;
    assign bus.enable_encoder_i = en_q;
    assign bus.err_inj          = inj_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.bit_err_ct       = bit_err_q;
    assign bus.inj_ct           = inj_ct_q;

endmodule

`default_nettype wire

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame sequencer and scorer for the convolutional-encoder / channel / Viterbi-decoder test path. On `start` it drives one pseudo-random payload frame plus a zero tail into the encoder. It schedules per-symbol channel error injection, then compares decoder output against a delayed copy of the payload and counts bit errors. It sits in the tx/rx wrapper in place of free-running stimulus and ad-hoc error logic.

## Interface

Parameters:
- `FRAME_LEN`, 256: payload bits per frame.
- `TAIL_LEN`, 8: zero flush bits after the payload.
- `DEC_LAT`, 40: cycles from an encoder-enable cycle to the matching `decoder_o` bit. Must satisfy TAIL_LEN < DEC_LAT ≤ 64.
- `ERR_W`, 5: width of the injection-trigger compare field (sets the error-rate granularity, 1/2**ERR_W).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a frame; sampled only in IDLE.
- `abort`, in, 1: end the current frame immediately, no `done`.
- `seed`, in, 16: payload LFSR seed, latched on accepted `start`.
- `err_thresh`, in, ERR_W+1: injection threshold, latched on accepted `start`.
- `encoder_i`, out, 1: payload/tail bit to the encoder.
- `enable_encoder_i`, out, 1: encoder enable.
- `err_inj`, out, 2: channel XOR mask, aligned with `enable_encoder_i`.
- `decoder_o`, in, 1: decoded bit from the decoder.
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse, frame complete.
- `bit_err_ct`, out, 16: payload bits decoded wrong; saturating.
- `inj_ct`, out, 16: symbols with nonzero `err_inj`; saturating.

## Operation

- States: IDLE, RUN, FLUSH, DRAIN, DONE.
- IDLE → RUN on `start`. On the same edge:
  - latch `seed` and `err_thresh`;
  - clear both counters and the cycle counter.
- RUN lasts FRAME_LEN cycles. `enable_encoder_i`=1 and `encoder_i`=payload LFSR bit[0]. The LFSR advances each RUN cycle.
- RUN → FLUSH. FLUSH lasts TAIL_LEN cycles with `enable_encoder_i`=1 and `encoder_i`=0.
- FLUSH → DRAIN. `enable_encoder_i`=0. DRAIN is held until the compare window closes.
- DRAIN → DONE, then DONE → IDLE after one cycle.
- Payload LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1;
  - shifts left, new bit0 = b15^b13^b12^b10;
  - seed 0 is replaced by 16'hACE1.
- Error LFSR:
  - same polynomial, seeded with the byte-swapped seed; 0 is replaced by 16'h1D0F;
  - advances every enabled cycle.
- Injection: on each enabled cycle, `err_inj`=2'b01 when err_lfsr[ERR_W-1:0] < err_thresh, else 2'b00. Outside enabled cycles `err_inj`=0.
  - err_thresh=0 means no errors; err_thresh=2**ERR_W means every symbol is corrupted.
  - `inj_ct` increments on each nonzero `err_inj`.
- Compare:
  - Each payload bit (RUN only) enters a DEC_LAT-deep reference shift register with a valid tag.
  - When a valid tagged bit exits, it is XORed with `decoder_o`; a mismatch increments `bit_err_ct`.
  - Tail bits are never scored.
- Counters saturate at 16'hFFFF. Results hold after DONE until the next accepted `start`.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state:
  - next state IDLE; `enable_encoder_i`, `err_inj`, `busy` deassert next cycle;
  - counters hold; `done` does not pulse;
  - the reference pipe is flushed.
- `rst` has priority over everything. It forces IDLE and zeroes all outputs, counters, LFSRs and the reference pipe, including mid-frame.
- If `abort` and `start` are high together in IDLE, `start` wins. `abort` is only meaningful when not IDLE.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `start` accepted at edge t:
  - first enabled cycle is t+1; last enabled cycle is t+FRAME_LEN+TAIL_LEN;
  - payload bit k is driven at t+1+k and scored against `decoder_o` sampled at t+1+k+DEC_LAT;
  - last compare at t+FRAME_LEN+DEC_LAT;
  - `done`=1 at cycle t+FRAME_LEN+DEC_LAT+1.
- `busy` is high from t+1 through the DONE cycle inclusive. `bit_err_ct` is final when `done` is high.
- A new `start` is accepted no earlier than the cycle after DONE.

## Structure

- Package `viterbi_ctrl_pkg` holds:
  - state enum `vctrl_state_t`;
  - LFSR tap constant;
  - seed-substitute constants 16'hACE1 and 16'h1D0F.
- Sub-module `lfsr16` (load, advance, seed-zero substitution) is instantiated twice.
- The FSM, cycle counter, reference pipe and counters live in the top module.

## Test plan

- Reset: hold `rst` 3 cycles, then release with idle inputs → all outputs 0 and `busy` stays 0.
- Clean frame:
  - setup: seed=16'h1234, err_thresh=0, ideal decoder model (payload delayed DEC_LAT);
  - expect 264 enabled cycles, `done` at t+297, `bit_err_ct`=0, `inj_ct`=0.
- Full injection: err_thresh=32 (ERR_W=5) → `err_inj`=2'b01 on all 264 enabled cycles, `inj_ct`=264.
- Inverting decoder model, err_thresh=0 → `bit_err_ct`=256, proving tail bits are unscored.
- Reset mid-RUN at k=100 → next cycle all outputs 0. A restart with the same seed reproduces the identical `encoder_i` sequence from bit 0.
- Interrupts:
  - `start` pulsed during FLUSH → ignored, same `done` cycle as without the pulse;
  - `abort` in DRAIN → `busy` falls next cycle, no `done`, counters hold.
